// File: rtl/descrambler_arb_ctrl_pkg.sv
// Shared types and constants for the descrambler front-end arbiter/controller.
package bbp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STREAM      = 3'd1,
    FLUSH       = 3'd2,
    DRAIN_FLUSH = 3'd3,
    DRAIN       = 3'd4
  } dscr_ctrl_state_t;

  localparam int DSCR_FRAME_LEN     = 255;
  localparam int DSCR_DRAIN_TIMEOUT = 2048;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/descrambler_arb_ctrl_if.sv
// Byte-wide valid/ready stream used for both demod lanes and the descrambler input.
interface descrambler_arb_ctrl_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/descrambler_arb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the lane that did not win last time is chosen.
module dscr_rr_arb2
  import bbp_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  assign grant_valid = |req;
  assign grant       = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/descrambler_arb_ctrl.sv
// Two-lane front end for the frame descrambler: round-robin grant, fixed-length framing,
// drain hand-off with lane tagging, and gap/length/timeout error counting.
//
// state       | meaning
// IDLE        | no lane granted, waiting for any request
// STREAM      | granted lane forwarded to descrambler, bytes counted
// FLUSH       | discarding rest of a broken frame, then IDLE
// DRAIN_FLUSH | discarding tail of a long frame while watching descrambler output
// DRAIN       | waiting for descrambler output tlast or timeout
module descrambler_arb_ctrl
  import bbp_ctrl_pkg::*;
#(
  parameter int FRAME_LEN     = DSCR_FRAME_LEN,
  parameter int DRAIN_TIMEOUT = DSCR_DRAIN_TIMEOUT,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  descrambler_arb_ctrl_if.slave  s0,
  descrambler_arb_ctrl_if.slave  s1,
  descrambler_arb_ctrl_if.master m,
  input  logic                   dscr_tvalid,
  input  logic                   dscr_tlast,
  output logic                   out_lane,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_cnt0,
  output logic [CNT_W-1:0]       frame_cnt1,
  output logic [7:0]             gap_err_cnt,
  output logic [7:0]             len_err_cnt,
  output logic [7:0]             tmo_err_cnt
);

  localparam int BCW = $clog2(FRAME_LEN);
  localparam int DCW = $clog2(DRAIN_TIMEOUT);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(FRAME_LEN - 1);
  localparam logic [DCW-1:0] TMO_IDX  = DCW'(DRAIN_TIMEOUT - 1);

  dscr_ctrl_state_t state_q, state_d;
  logic             grant_q, last_grant_q, out_lane_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [DCW-1:0]   drain_cnt_q;

  logic       arb_valid, arb_grant;
  logic       sg_tvalid, sg_tlast, sg_tready;
  logic [7:0] sg_tdata;
  logic       m_tvalid_c, m_tlast_c;
  logic       take_grant, cnt_inc, drain_clr, drain_inc, latch_out;
  logic       inc_gap, inc_len, inc_tmo, inc_frame;
  logic       dscr_hit, drain_tmo, flush_end;

  dscr_rr_arb2 u_arb (
    .req         ({s1.tvalid, s0.tvalid}),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  assign sg_tvalid = grant_q ? s1.tvalid : s0.tvalid;
  assign sg_tdata  = grant_q ? s1.tdata  : s0.tdata;
  assign sg_tlast  = grant_q ? s1.tlast  : s0.tlast;

  assign s0.tready = sg_tready & ~grant_q;
  assign s1.tready = sg_tready &  grant_q;
  assign m.tvalid  = m_tvalid_c;
  assign m.tlast   = m_tlast_c;
  assign m.tdata   = (state_q == STREAM) ? sg_tdata : 8'h00;

  assign dscr_hit  = dscr_tvalid & dscr_tlast;
  assign drain_tmo = (drain_cnt_q == TMO_IDX);
  assign flush_end = sg_tvalid & sg_tlast;
  assign busy      = (state_q != IDLE);
  assign out_lane  = out_lane_q;

  always_comb begin
    state_d    = state_q;
    sg_tready  = 1'b0;
    m_tvalid_c = 1'b0;
    m_tlast_c  = 1'b0;
    take_grant = 1'b0;
    cnt_inc    = 1'b0;
    drain_clr  = 1'b0;
    drain_inc  = 1'b0;
    latch_out  = 1'b0;
    inc_gap    = 1'b0;
    inc_len    = 1'b0;
    inc_tmo    = 1'b0;
    inc_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          take_grant = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        m_tvalid_c = sg_tvalid;
        m_tlast_c  = (byte_cnt_q == LAST_IDX);
        sg_tready  = m.tready;
        // a stalled descrambler input is a hold, never a gap
        if (m.tready) begin
          if (!sg_tvalid) begin
            if (byte_cnt_q != '0) begin
              inc_gap = 1'b1;
              state_d = FLUSH;
            end
          end else if (byte_cnt_q == LAST_IDX) begin
            latch_out = 1'b1;
            drain_clr = 1'b1;
            if (sg_tlast) begin
              state_d = DRAIN;
            end else begin
              inc_len = 1'b1;
              state_d = DRAIN_FLUSH;
            end
          end else if (sg_tlast) begin
            inc_len = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FLUSH: begin
        sg_tready = 1'b1;
        if (flush_end) state_d = IDLE;
      end
      DRAIN_FLUSH: begin
        sg_tready = 1'b1;
        drain_inc = 1'b1;
        if (dscr_hit)       inc_frame = 1'b1;
        else if (drain_tmo) inc_tmo   = 1'b1;
        // once the drain resolves, only the flush remains outstanding
        if (flush_end)                  state_d = (dscr_hit || drain_tmo) ? IDLE : DRAIN;
        else if (dscr_hit || drain_tmo) state_d = FLUSH;
      end
      DRAIN: begin
        drain_inc = 1'b1;
        if (dscr_hit) begin
          inc_frame = 1'b1;
          state_d   = IDLE;
        end else if (drain_tmo) begin
          inc_tmo = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      out_lane_q   <= 1'b0;
      byte_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      frame_cnt0   <= '0;
      frame_cnt1   <= '0;
      gap_err_cnt  <= '0;
      len_err_cnt  <= '0;
      tmo_err_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        grant_q      <= arb_grant;
        last_grant_q <= arb_grant;
        byte_cnt_q   <= '0;
      end else if (cnt_inc) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (drain_clr)      drain_cnt_q <= '0;
      else if (drain_inc) drain_cnt_q <= drain_cnt_q + 1'b1;
      if (latch_out) out_lane_q <= grant_q;
      if (inc_frame) begin
        if (out_lane_q) frame_cnt1 <= frame_cnt1 + 1'b1;
        else            frame_cnt0 <= frame_cnt0 + 1'b1;
      end
      if (inc_gap) gap_err_cnt <= sat_inc8(gap_err_cnt);
      if (inc_len) len_err_cnt <= sat_inc8(len_err_cnt);
      if (inc_tmo) tmo_err_cnt <= sat_inc8(tmo_err_cnt);
    end
  end

endmodule

// File: tb/tb_descrambler_arb_ctrl.sv
// Bench for descrambler_arb_ctrl: directed scenarios plus randomized frames, every cycle
// compared against a frame-level behavioural model of the controller.
module tb_descrambler_arb_ctrl;
  localparam int FL = 255;
  localparam int TO = 2048;
  localparam int CW = 16;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dscr_tvalid = 1'b0;
  logic dscr_tlast = 1'b0;
  logic out_lane, busy;
  logic [CW-1:0] frame_cnt0, frame_cnt1;
  logic [7:0] gap_err_cnt, len_err_cnt, tmo_err_cnt;

  descrambler_arb_ctrl_if s0_if ();
  descrambler_arb_ctrl_if s1_if ();
  descrambler_arb_ctrl_if m_if ();

  always #5 clk = ~clk;

  descrambler_arb_ctrl #(.FRAME_LEN(FL), .DRAIN_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .s0          (s0_if),
    .s1          (s1_if),
    .m           (m_if),
    .dscr_tvalid (dscr_tvalid),
    .dscr_tlast  (dscr_tlast),
    .out_lane    (out_lane),
    .busy        (busy),
    .frame_cnt0  (frame_cnt0),
    .frame_cnt1  (frame_cnt1),
    .gap_err_cnt (gap_err_cnt),
    .len_err_cnt (len_err_cnt),
    .tmo_err_cnt (tmo_err_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  item_t lq[2][$];
  bit    consumed[2];
  bit    rand_ready = 1'b0;
  int    dscr_delay = 0;
  int    dscr_cd = -1;
  int    m_beats = 0, m_lasts = 0;
  int    lane_beats[2] = '{0, 0};
  int    drain_len = 0, drain_run = 0;
  bit    draining = 1'b0;
  int    glog[$];
  bit    want_log = 1'b0;
  logic  busy_prev = 1'b0;

  // behavioural model: phase 0 idle, 1 sending, 2 discarding, 3 discarding while awaiting
  // the descrambler, 4 awaiting the descrambler
  int md = 0, ln = 0, prv = 1, sent = 0, waitc = 0, olane = 0;
  int frames[2] = '{0, 0};
  int gapc = 0, lenc = 0, tmoc = 0;

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int lane, input int n, input int gap_at, input int gap_len,
                            input int base);
    item_t it;
    item_t idle_it;
    idle_it = '0;
    for (int i = 1; i <= n; i++) begin
      if (i == gap_at + 1)
        for (int g = 0; g < gap_len; g++) lq[lane].push_back(idle_it);
      it.v = 1'b1;
      it.d = 8'(base + i);
      it.l = (i == n);
      lq[lane].push_back(it);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    lq[0].delete();
    lq[1].delete();
    dscr_cd = -1;
    draining = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  c;
    bit  done;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      done = (lq[0].size() == 0) && (lq[1].size() == 0) && !busy && (dscr_cd < 0) && !dscr_tvalid;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  // stimulus driver: lanes, descrambler input ready, descrambler output monitor pulse
  initial begin
    item_t h;
    s0_if.tvalid = 1'b0; s0_if.tdata = 8'h00; s0_if.tlast = 1'b0;
    s1_if.tvalid = 1'b0; s1_if.tdata = 8'h00; s1_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int l = 0; l < 2; l++)
        if (consumed[l] && lq[l].size() > 0) void'(lq[l].pop_front());
      h = (lq[0].size() > 0) ? lq[0][0] : '0;
      s0_if.tvalid = h.v; s0_if.tdata = h.d; s0_if.tlast = h.l;
      h = (lq[1].size() > 0) ? lq[1][0] : '0;
      s1_if.tvalid = h.v; s1_if.tdata = h.d; s1_if.tlast = h.l;
      m_if.tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (dscr_cd == 0) begin
        dscr_tvalid = 1'b1; dscr_tlast = 1'b1; dscr_cd = -1;
      end else begin
        dscr_tvalid = 1'b0; dscr_tlast = 1'b0;
        if (dscr_cd > 0) dscr_cd--;
      end
    end
  end

  // compare process: model vs DUT every cycle, then advance the model
  initial begin
    logic       sv[2], sl[2], rdy[2];
    logic [7:0] sd[2];
    logic       e_mv, e_ml;
    logic       e_r[2];
    bit         hit, done, fend;
    forever begin
      @(negedge clk);
      sv[0] = s0_if.tvalid; sl[0] = s0_if.tlast; sd[0] = s0_if.tdata; rdy[0] = s0_if.tready;
      sv[1] = s1_if.tvalid; sl[1] = s1_if.tlast; sd[1] = s1_if.tdata; rdy[1] = s1_if.tready;
      e_mv = 1'b0; e_ml = 1'b0; e_r[0] = 1'b0; e_r[1] = 1'b0;
      if (md == 1) begin
        e_mv = sv[ln];
        e_ml = (sent == FL - 1);
        e_r[ln] = m_if.tready;
      end else if (md == 2 || md == 3) begin
        e_r[ln] = 1'b1;
      end
      chk("m_tvalid", 32'(m_if.tvalid), 32'(e_mv));
      chk("m_tlast", 32'(m_if.tlast), 32'(e_ml));
      if (e_mv) chk("m_tdata", 32'(m_if.tdata), 32'(sd[ln]));
      chk("s0_tready", 32'(rdy[0]), 32'(e_r[0]));
      chk("s1_tready", 32'(rdy[1]), 32'(e_r[1]));
      chk("busy", 32'(busy), 32'(md != 0));
      chk("out_lane", 32'(out_lane), 32'(olane));
      chk("frame_cnt0", 32'(frame_cnt0), frames[0] & 32'hFFFF);
      chk("frame_cnt1", 32'(frame_cnt1), frames[1] & 32'hFFFF);
      chk("gap_err_cnt", 32'(gap_err_cnt), 32'(gapc));
      chk("len_err_cnt", 32'(len_err_cnt), 32'(lenc));
      chk("tmo_err_cnt", 32'(tmo_err_cnt), 32'(tmoc));

      if (m_if.tvalid && m_if.tready) begin
        m_beats++;
        if (m_if.tlast) begin
          m_lasts++;
          if (dscr_delay > 0) dscr_cd = dscr_delay - 1;
          draining = 1'b1;
          drain_run = 0;
        end
      end else if (draining) begin
        if (busy) drain_run++;
        else begin
          draining = 1'b0;
          drain_len = drain_run;
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (sv[l] && rdy[l]) lane_beats[l]++;
        consumed[l] = (lq[l].size() > 0) && (!lq[l][0].v || rdy[l]);
      end
      if (!busy_prev && busy) want_log = 1'b1;
      if (want_log && (rdy[0] || rdy[1])) begin
        glog.push_back(rdy[1] ? 1 : 0);
        want_log = 1'b0;
      end
      busy_prev = busy;

      hit = dscr_tvalid && dscr_tlast;
      if (reset) begin
        md = 0; ln = 0; prv = 1; sent = 0; waitc = 0; olane = 0;
        frames[0] = 0; frames[1] = 0; gapc = 0; lenc = 0; tmoc = 0;
      end else begin
        case (md)
          0: if (sv[0] || sv[1]) begin
               ln = (sv[0] && sv[1]) ? 1 - prv : (sv[0] ? 0 : 1);
               prv = ln; sent = 0; md = 1;
             end
          1: if (m_if.tready) begin
               if (!sv[ln]) begin
                 if (sent > 0) begin gapc = sat(gapc); md = 2; end
               end else if (sent == FL - 1) begin
                 olane = ln; waitc = 0;
                 if (sl[ln]) md = 4;
                 else begin lenc = sat(lenc); md = 3; end
               end else if (sl[ln]) begin
                 lenc = sat(lenc); md = 0;
               end else begin
                 sent++;
               end
             end
          2: if (sv[ln] && sl[ln]) md = 0;
          3: begin
               done = hit || (waitc == TO - 1);
               if (hit) frames[olane]++;
               else if (waitc == TO - 1) tmoc = sat(tmoc);
               fend = sv[ln] && sl[ln];
               md = fend ? (done ? 0 : 4) : (done ? 2 : 3);
               waitc++;
             end
          4: begin
               if (hit) begin frames[olane]++; md = 0; end
               else if (waitc == TO - 1) begin tmoc = sat(tmoc); md = 0; end
               else waitc++;
             end
          default: md = 0;
        endcase
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_m, b_l, b_l0, b_l1, c, kind, len, mask;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_s0_tready", 32'(s0_if.tready), 32'd0);
    chk("rst_s1_tready", 32'(s1_if.tready), 32'd0);
    chk("rst_frame_cnt0", 32'(frame_cnt0), 32'd0);

    // lane0 clean frame, descrambler answers after 300 drain cycles
    dscr_delay = 300;
    b_m = m_beats; b_l = m_lasts;
    push_frame(0, 255, -1, 0, 0);
    wait_idle(2000, "t1_idle");
    chk("t1_frame_cnt0", 32'(frame_cnt0), 32'd1);
    chk("t1_out_lane", 32'(out_lane), 32'd0);
    chk("t1_m_beats", 32'(m_beats - b_m), 32'd255);
    chk("t1_m_lasts", 32'(m_lasts - b_l), 32'd1);
    chk("t1_drain_len", 32'(drain_len), 32'd300);

    // simultaneous requests from reset, lane0 re-requests
    do_reset();
    glog.delete();
    dscr_delay = 20;
    push_frame(0, 255, -1, 0, 8'h10);
    push_frame(1, 255, -1, 0, 8'h80);
    push_frame(0, 255, -1, 0, 8'h20);
    wait_idle(3000, "t2_idle");
    chk("t2_grants", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("t2_grant0", 32'(glog[0]), 32'd0);
      chk("t2_grant1", 32'(glog[1]), 32'd1);
      chk("t2_grant2", 32'(glog[2]), 32'd0);
    end
    chk("t2_frame_cnt0", 32'(frame_cnt0), 32'd2);
    chk("t2_frame_cnt1", 32'(frame_cnt1), 32'd1);

    // lane1 gap after byte 100
    do_reset();
    b_m = m_beats; b_l = m_lasts; b_l1 = lane_beats[1];
    push_frame(1, 255, 100, 5, 8'h40);
    wait_idle(2000, "t3_idle");
    chk("t3_gap_err", 32'(gap_err_cnt), 32'd1);
    chk("t3_m_beats", 32'(m_beats - b_m), 32'd100);
    chk("t3_lane1_beats", 32'(lane_beats[1] - b_l1), 32'd255);
    chk("t3_m_lasts", 32'(m_lasts - b_l), 32'd0);

    // early tlast at byte 200, then a 260-byte frame
    do_reset();
    dscr_delay = 50;
    b_m = m_beats; b_l = m_lasts; b_l0 = lane_beats[0];
    push_frame(0, 200, -1, 0, 0);
    push_frame(0, 260, -1, 0, 8'h33);
    wait_idle(3000, "t4_idle");
    chk("t4_len_err", 32'(len_err_cnt), 32'd2);
    chk("t4_frame_cnt0", 32'(frame_cnt0), 32'd1);
    chk("t4_m_beats", 32'(m_beats - b_m), 32'd455);
    chk("t4_lane0_beats", 32'(lane_beats[0] - b_l0), 32'd460);
    chk("t4_m_lasts", 32'(m_lasts - b_l), 32'd1);

    // drain timeout, then reset in the middle of a frame
    do_reset();
    dscr_delay = 0;
    push_frame(1, 255, -1, 0, 8'h55);
    wait_idle(4000, "t5_idle");
    chk("t5_tmo_err", 32'(tmo_err_cnt), 32'd1);
    chk("t5_drain_len", 32'(drain_len), 32'(TO));
    chk("t5_frame_cnt1", 32'(frame_cnt1), 32'd0);
    b_m = m_beats;
    push_frame(0, 255, -1, 0, 0);
    c = 0;
    while (m_beats - b_m < 50 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reached_byte50", 32'(m_beats - b_m), 32'd50);
    do_reset();
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tmo_err", 32'(tmo_err_cnt), 32'd0);
    chk("t6_out_lane", 32'(out_lane), 32'd0);
    chk("t6_s0_tready", 32'(s0_if.tready), 32'd0);

    // randomized frames on random lanes with random descrambler input stalls
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      dscr_delay = int'($urandom_range(1, 400));
      mask = int'($urandom_range(1, 3));
      for (int l = 0; l < 2; l++) begin
        if (mask[l]) begin
          kind = int'($urandom_range(0, 7));
          case (kind)
            0: begin
                 len = int'($urandom_range(1, 254));
                 push_frame(l, len, -1, 0, int'($urandom_range(0, 255)));
               end
            1: begin
                 len = int'($urandom_range(256, 262));
                 push_frame(l, len, -1, 0, int'($urandom_range(0, 255)));
               end
            2: push_frame(l, FL, int'($urandom_range(1, 254)), int'($urandom_range(1, 4)),
                          int'($urandom_range(0, 255)));
            default: push_frame(l, FL, -1, 0, int'($urandom_range(0, 255)));
          endcase
        end
      end
      wait_idle(5000, "rnd_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
